// File: rtl/es5503_mixer.sv
// Stereo mixer behind the DOC oscillator engine: accumulates per-slot products, scales,
// saturates and hands out one stereo sample per scan. Optional peak meters: ES5503_MIX_PEAK_EN.
module es5503_mixer #(
  parameter int unsigned SHIFT = 3,
  parameter int unsigned ACC_W = 21
) (
  input  logic        CLK_14M,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  input  logic [3:0]  ca_in,
  input  logic [4:0]  osc_count,
  input  logic        out_ready,
  input  logic        clr_overrun,
  output logic        out_valid,
  output logic [15:0] out_left,
  output logic [15:0] out_right,
`ifdef ES5503_MIX_PEAK_EN
  input  logic        peak_clr,
  output logic [14:0] peak_l,
  output logic [14:0] peak_r,
`endif
  output logic        overrun
);

  localparam int unsigned SAMP_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_out_valid;
  logic [SAMP_W-1:0]       r_out_left, r_out_right;
  logic                    r_overrun;

  logic signed [ACC_W-1:0] w_ext, w_add_l, w_add_r, w_sum_l, w_sum_r, w_shl, w_shr;
  logic [SAMP_W-1:0]       w_sat_l, w_sat_r;
  logic                    w_done, w_load, w_drop;
  logic                    w_unused;

  function automatic logic [SAMP_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      sat16 = 16'h7FFF;
    else if (v < SAT_MIN) sat16 = 16'h8000;
    else                  sat16 = v[SAMP_W-1:0];
  endfunction

  // Only bit 0 of the channel assignment picks a side.
  assign w_unused = ^ca_in[3:1];

  assign w_ext   = {{(ACC_W-SAMP_W){sample_in[SAMP_W-1]}}, sample_in};
  assign w_add_l = (sample_valid && !ca_in[0]) ? w_ext : '0;
  assign w_add_r = (sample_valid &&  ca_in[0]) ? w_ext : '0;
  assign w_sum_l = r_acc_l + w_add_l;
  assign w_sum_r = r_acc_r + w_add_r;
  assign w_shl   = w_sum_l >>> SHIFT;
  assign w_shr   = w_sum_r >>> SHIFT;
  assign w_sat_l = sat16(w_shl);
  assign w_sat_r = sat16(w_shr);

  // A lowered osc_count mid-frame still ends the frame on the next sample.
  assign w_done = sample_valid && (r_cnt >= osc_count);
  assign w_load = w_done && (!r_out_valid || out_ready);
  assign w_drop = w_done && r_out_valid && !out_ready;

  always_ff @(posedge CLK_14M) begin
    if (!reset_n) begin
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_left  <= 16'h0000;
      r_out_right <= 16'h0000;
      r_overrun   <= 1'b0;
    end else begin
      if (w_done) begin
        r_acc_l <= '0;
        r_acc_r <= '0;
        r_cnt   <= '0;
      end else if (sample_valid) begin
        r_acc_l <= w_sum_l;
        r_acc_r <= w_sum_r;
        r_cnt   <= r_cnt + CNT_W'(1);
      end

      if (w_load) begin
        r_out_left  <= w_sat_l;
        r_out_right <= w_sat_r;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop)           r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign overrun   = r_overrun;

`ifdef ES5503_MIX_PEAK_EN
  logic [14:0] r_peak_l, r_peak_r;
  logic [14:0] w_abs_l, w_abs_r, w_base_l, w_base_r;

  // Magnitude of a signed sample; -32768 clips to 32767 so it fits 15 bits.
  function automatic logic [14:0] abs15(input logic [SAMP_W-1:0] x);
    logic [SAMP_W-1:0] neg;
    neg = SAMP_W'(~x + SAMP_W'(1));
    if (x == 16'h8000)      abs15 = 15'h7FFF;
    else if (x[SAMP_W-1])   abs15 = neg[14:0];
    else                    abs15 = x[14:0];
  endfunction

  assign w_abs_l  = abs15(w_sat_l);
  assign w_abs_r  = abs15(w_sat_r);
  assign w_base_l = peak_clr ? 15'h0000 : r_peak_l;
  assign w_base_r = peak_clr ? 15'h0000 : r_peak_r;

  always_ff @(posedge CLK_14M) begin
    if (!reset_n) begin
      r_peak_l <= '0;
      r_peak_r <= '0;
    end else if (w_load) begin
      r_peak_l <= (w_abs_l > w_base_l) ? w_abs_l : w_base_l;
      r_peak_r <= (w_abs_r > w_base_r) ? w_abs_r : w_base_r;
    end else if (peak_clr) begin
      r_peak_l <= '0;
      r_peak_r <= '0;
    end
  end

  assign peak_l = r_peak_l;
  assign peak_r = r_peak_r;
`endif

endmodule

// File: doc/es5503_mixer.md
Name: es5503_mixer

Overview:
- Sits directly downstream of the DOC oscillator engine.
- Takes one signed 16-bit oscillator product per oscillator slot, plus that slot's channel-assignment nibble.
- Accumulates the products into left and right sums over one full scan of the enabled oscillators.
- At the end of each scan, scales and saturates both sums and presents one stereo sample to the audio output path through a ready/valid handshake.

Parameters:
- SHIFT, 3, arithmetic right shift applied to each accumulated sum before saturation.
- ACC_W, 21, accumulator width in bits; must be at least 21 (32 × 16-bit signed).

Ports:
- CLK_14M  input  1  system clock.
- reset_n  input  1  synchronous reset, active-low.
- sample_valid  input  1  one-cycle strobe; sample_in and ca_in are valid this cycle.
- sample_in  input  16  signed oscillator product (volume × signed sample).
- ca_in  input  4  channel assignment of the oscillator; bit 0 selects the side.
- osc_count  input  5  number of enabled oscillators minus 1 (0..31).
- out_ready  input  1  downstream accepts out_left/out_right this cycle.
- clr_overrun  input  1  clears the overrun flag.
- out_valid  output  1  stereo sample available.
- out_left  output  16  signed left sample.
- out_right  output  16  signed right sample.
- overrun  output  1  sticky flag: a completed frame was dropped.

Behaviour:
- Reset: reset_n low at a clock edge clears the following.
  - acc_l, acc_r, slot counter: 0.
  - out_valid: 0.
  - out_left, out_right: 16'h0000.
  - overrun: 0.
  - Reset mid-frame discards the partial sums.
- Accept: on sample_valid, sample_in is sign-extended to ACC_W.
  - ca_in[0]=0: added to acc_l.
  - ca_in[0]=1: added to acc_r.
  - The other accumulator is unchanged.
  - A sample of 16'h0000 (halted oscillator) still counts as a slot.
- Slot counter: 5-bit, increments on each accepted sample.
  - Frame completes on the accepted sample where counter ≥ osc_count.
  - This includes the case where osc_count is lowered mid-frame below the current count.
  - On completion the counter returns to 0.
- Completion cycle:
  - Final sums include the completing sample.
  - Both accumulators reload to 0, not to the completing sample.
- Scaling: each final sum is arithmetically shifted right by SHIFT, then saturated to 16-bit signed.
  - Values above 32767 become 16'h7FFF.
  - Values below -32768 become 16'h8000.
- Output register:
  - The result loads into out_left/out_right, and out_valid rises, on the clock edge after the completing sample.
  - Latency is 1 cycle.
- Handshake:
  - out_valid stays high and the outputs stay stable until a cycle with out_ready=1, after which out_valid falls.
  - If a frame completes while out_valid=1 and out_ready=0, the new result is dropped, the held output is unchanged, and overrun is set.
  - If a frame completes in the same cycle that out_ready=1 with out_valid=1, the new result loads and out_valid stays 1. This is not an overrun.
- Overrun:
  - Cleared by clr_overrun.
  - If set and clear coincide, set wins.
- sample_valid arriving every cycle is legal; there is no back-pressure on the input side.
- ca_in[3:1] are ignored.

Optional Feature:
- Macro: ES5503_MIX_PEAK_EN.
- When defined, the block adds two outputs, peak_l and peak_r, each 15 bits, plus a peak_clr input (1 bit).
- Each peak output holds the maximum absolute value of out_left or out_right respectively, taken at each output load.
  - Absolute value of 16'h8000 is treated as 16'h7FFF.
- peak_clr zeroes both peaks. A load in the same cycle as peak_clr wins.
- Reset zeroes both peaks.
- When not defined, these ports and registers are absent and the remaining behaviour is identical.

Test Plan:
- Basic mix:
  - Stimulus: osc_count=1, SHIFT=0, out_ready=1. Samples 16'h0100 with ca=0, then 16'hFF00 with ca=1.
  - Required: one cycle later, out_valid=1, out_left=16'h0100, out_right=16'hFF00.
- Full scan:
  - Stimulus: osc_count=31, SHIFT=3, 32 samples of 16'h7FFF with ca=0.
  - Required: acc_l=1048544; shifted result 131068 saturates, so out_left=16'h7FFF and out_right=0.
- Negative saturation:
  - Stimulus: osc_count=31, SHIFT=3, 32 samples of 16'h8000 with ca=1.
  - Required: out_right=16'h8000.
- Overrun and back-to-back handshake:
  - Stimulus: out_ready=0, osc_count=0, two samples of 16'h0010 (ca=0) then 16'h0020 (ca=0).
  - Required: out_left holds 16'h0010 and overrun=1.
  - Then raise out_ready in the same cycle as the completing sample 16'h0030: out_left=16'h0030, out_valid stays 1, overrun stays 1 until clr_overrun.
- Mid-frame changes:
  - Stimulus: osc_count=7. After 3 samples, set osc_count=1.
  - Required: frame completes on the 4th sample (counter 3 ≥ 1); the next frame starts from count 0.
  - Stimulus: pull reset_n low after 2 samples.
  - Required: all outputs are zero, and the next frame sums only post-reset samples.
